// File: rtl/led_seq_pkg.sv
//============================================================================
// Module : led_seq_pkg
// Brief  : Shared types and constants for the LED pattern sequencer.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_FILL  = 2'd2,
        MODE_BLINK = 2'd3
    } led_mode_e;

    localparam int SYNC_STAGES = 2;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
//============================================================================
// Module : btn_debounce
// Brief  : Raw button synchroniser + debouncer emitting a 1-cycle press pulse.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module btn_debounce
    import led_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 240000
)(
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int              c_DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DW-1:0] c_DB_LAST = c_DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic [c_DW-1:0]        r_cnt;
    logic                   r_level;
    logic                   r_armed;
    logic                   r_press;
    logic                   w_sync;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign o_press = r_press;

    // r_armed stays low until a released level has been seen after reset, so a
    // button held through reset cannot produce a press when reset drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_vld   <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_armed <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_vld   <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_press <= 1'b0;
            if (r_vld[SYNC_STAGES-1] && !w_sync)
                r_armed <= 1'b1;
            if (w_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DB_LAST) begin
                r_cnt   <= '0;
                r_level <= w_sync;
                r_press <= w_sync & r_armed;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_seq_ctrl.sv
//============================================================================
// Module : led_seq_ctrl
// Brief  : Four-pattern LED sequencer with debounced mode/pause buttons.
//          Optional PWM dimming enabled by defining LED_SEQ_PWM_DIM_EN.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV        = 12000000,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int NUM_LEDS        = 8
)(
    input  logic                hwclk,
    input  logic                rst,
    input  logic                btn_mode,
    input  logic                btn_pause,
`ifdef LED_SEQ_PWM_DIM_EN
    input  logic [3:0]          bright,
`endif
    output logic [NUM_LEDS-1:0] leds,
    output logic [1:0]          mode,
    output logic                paused,
    output logic                tick
);

    localparam int              c_TW        = $clog2(TICK_DIV);
    localparam int              c_SW        = $clog2(NUM_LEDS + 1);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);
    localparam logic [c_SW-1:0] c_LAST      = c_SW'(NUM_LEDS - 1);
    localparam logic [c_SW-1:0] c_FULL      = c_SW'(NUM_LEDS);

    logic [c_TW-1:0]     r_tick_cnt;
    logic [c_SW-1:0]     r_step;
    logic                r_dir;
    logic [NUM_LEDS-1:0] r_pat;
    led_mode_e           r_mode;
    logic                r_paused;

    logic                w_mode_press;
    logic                w_pause_press;
    logic                w_tick;
    logic [c_SW-1:0]     w_step_nxt;
    logic                w_dir_nxt;
    logic [NUM_LEDS-1:0] w_pat_nxt;
    logic [NUM_LEDS-1:0] w_pat_init;
    led_mode_e           w_mode_nxt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_mode (
        .clk     (hwclk),
        .rst     (rst),
        .i_btn   (btn_mode),
        .o_press (w_mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_pause (
        .clk     (hwclk),
        .rst     (rst),
        .i_btn   (btn_pause),
        .o_press (w_pause_press)
    );

    assign w_tick     = !r_paused && (r_tick_cnt == c_TICK_LAST);
    assign w_mode_nxt = led_mode_e'(r_mode + 2'd1);
    assign w_pat_init = (w_mode_nxt == MODE_SCAN) ? {{(NUM_LEDS-1){1'b0}}, 1'b1} : '0;

    // SCAN direction flips as soon as an end is reached, so each end is lit once.
    always_comb begin
        w_step_nxt = r_step;
        w_dir_nxt  = r_dir;
        case (r_mode)
            MODE_SCAN: begin
                w_step_nxt = r_dir ? (r_step - 1'b1) : (r_step + 1'b1);
                if (w_step_nxt == c_LAST)
                    w_dir_nxt = 1'b1;
                else if (w_step_nxt == '0)
                    w_dir_nxt = 1'b0;
            end
            MODE_FILL:  w_step_nxt = (r_step == c_FULL) ? '0 : (r_step + 1'b1);
            MODE_BLINK: w_step_nxt = {{(c_SW-1){1'b0}}, ~r_step[0]};
            default: ;
        endcase
    end

    // COUNT uses the pattern register itself as its wider counter.
    always_comb begin
        w_pat_nxt = r_pat + 1'b1;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (r_mode)
                MODE_SCAN:  w_pat_nxt[i] = (w_step_nxt == c_SW'(i));
                MODE_FILL:  w_pat_nxt[i] = (c_SW'(i) < w_step_nxt);
                MODE_BLINK: w_pat_nxt[i] = w_step_nxt[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_step     <= '0;
            r_dir      <= 1'b0;
            r_pat      <= '0;
            r_mode     <= MODE_COUNT;
            r_paused   <= 1'b0;
        end else begin
            if (w_pause_press)
                r_paused <= ~r_paused;
            if (w_mode_press) begin
                r_mode     <= w_mode_nxt;
                r_tick_cnt <= '0;
                r_step     <= '0;
                r_dir      <= 1'b0;
                r_pat      <= w_pat_init;
            end else if (!r_paused) begin
                if (w_tick) begin
                    r_tick_cnt <= '0;
                    r_step     <= w_step_nxt;
                    r_dir      <= w_dir_nxt;
                    r_pat      <= w_pat_nxt;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end
        end
    end

`ifdef LED_SEQ_PWM_DIM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge hwclk) begin
        if (rst)
            r_pwm <= '0;
        else
            r_pwm <= r_pwm + 1'b1;
    end

    assign leds = r_pat & {NUM_LEDS{r_pwm < bright}};
`else
    assign leds = r_pat;
`endif

    assign mode   = r_mode;
    assign paused = r_paused;
    assign tick   = w_tick;

endmodule

`default_nettype wire
